// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator RMW bank.
//   acc_width()  : stored-sum width from partial-sum width plus guard bits
//   addr_width() : bank address width (at least 1 bit)
//   drain_state_e: drain engine states
//   sat_add()    : signed add clamped to a w-bit signed range (w <= 63)
package acc_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_DRAIN
    } drain_state_e;

    function automatic int acc_width(input int psum_w, input int guard);
        return psum_w + guard;
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Operands are already sign-extended to 64 bits, so the raw sum never wraps.
    function automatic longint sat_add(input longint a, input longint b, input int w);
        longint s;
        longint mx;
        longint mn;
        s  = a + b;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        if (s > mx) return mx;
        if (s < mn) return mn;
        return s;
    endfunction

endpackage

// File: rtl/accumulator_rmw_bank_bank.sv
// One accumulator column: DEPTH x ACC_WIDTH signed registers.
// Ports:
//   clk         clock
//   wr_en_i     write this cycle
//   wr_addr_i   write / RMW address
//   wr_first_i  1 = overwrite with sign-extended psum, 0 = saturating accumulate
//   psum_i      signed partial sum
//   rd_addr_i   combinational read address (drain side)
//   rd_data_o   mem[rd_addr_i]
//   ovf_o       this cycle's accumulate write clamped
module acc_bank
    import acc_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int PSUM_WIDTH = 19,
    parameter int ACC_WIDTH  = 23
) (
    input  logic                         clk,
    input  logic                         wr_en_i,
    input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
    input  logic                         wr_first_i,
    input  logic signed [PSUM_WIDTH-1:0] psum_i,
    input  logic [ADDR_WIDTH-1:0]        rd_addr_i,
    output logic [ACC_WIDTH-1:0]         rd_data_o,
    output logic                         ovf_o
);

    // Contents are deliberately not reset.
    logic signed [ACC_WIDTH-1:0] mem_q [DEPTH];
    logic signed [ACC_WIDTH-1:0] wr_data_d;
    longint                      cur;
    longint                      ext;
    longint                      raw;
    longint                      clamped;

    // Read of the old value is combinational, so a write in the previous
    // cycle to the same address is already visible here.
    always_comb begin
        cur       = longint'(mem_q[wr_addr_i]);
        ext       = longint'(psum_i);
        raw       = cur + ext;
        clamped   = sat_add(cur, ext, ACC_WIDTH);
        wr_data_d = wr_first_i ? {{(ACC_WIDTH-PSUM_WIDTH){psum_i[PSUM_WIDTH-1]}}, psum_i}
                               : ACC_WIDTH'(clamped);
        ovf_o     = wr_en_i & ~wr_first_i & (clamped != raw);
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_d;
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/accumulator_rmw_bank.sv
// Column-skewed read-modify-write output accumulator with a row drain engine.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   test_mode         1 = unskewed writes, data from psum_test
//   wr_en/addr/first  column-0 write tuple (skewed one cycle per column)
//   psum_in_flat      per-column signed partial sums, column i at slice i
//   psum_test         test data broadcast to all columns
//   drain_start/base/count  drain request (taken only in IDLE)
//   out_valid/ready/data    valid/ready row stream, column i at slice i
//   drain_done        one-cycle pulse at end of a drain
//   busy              drain engine not IDLE
//   ovf_flags         sticky per-column saturation flags
//   wr_conflict       sticky: write requested while busy
//   clear_flags       clears both sticky flag sets (wins over a set)
module accumulator_rmw_bank
    import acc_pkg::*;
#(
    parameter int SYSTOLIC_SIZE     = 8,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int ACTIVATION_WIDTH  = 8,
    parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
    parameter int GUARD_BITS        = 4,
    parameter int ACC_WIDTH         = acc_width(PARTIAL_SUM_WIDTH, GUARD_BITS),
    parameter int DEPTH             = 16,
    parameter int ADDR_WIDTH        = addr_width(DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   test_mode,
    input  logic                                   wr_en,
    input  logic [ADDR_WIDTH-1:0]                  wr_addr,
    input  logic                                   wr_first,
    input  logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0] psum_in_flat,
    input  logic [PARTIAL_SUM_WIDTH-1:0]           psum_test,
    input  logic                                   drain_start,
    input  logic [ADDR_WIDTH-1:0]                  drain_base,
    input  logic [ADDR_WIDTH:0]                    drain_count,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [ACC_WIDTH*SYSTOLIC_SIZE-1:0]     out_data,
    output logic                                   drain_done,
    output logic                                   busy,
    output logic [SYSTOLIC_SIZE-1:0]               ovf_flags,
    output logic                                   wr_conflict,
    input  logic                                   clear_flags
);

    localparam int S = SYSTOLIC_SIZE;  // assumed >= 2

    drain_state_e                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]                 rd_ptr_q, rd_ptr_d, nxt_ptr, rd_addr;
    logic [ADDR_WIDTH:0]                   remain_q, remain_d;
    logic                                  out_valid_q, out_valid_d;
    logic [S-1:0][ACC_WIDTH-1:0]           out_data_q, out_data_d;
    logic                                  done_q, done_d;
    logic [S-1:0]                          ovf_q;
    logic                                  conflict_q;

    logic                                  en0, en_in;
    logic [S-1:1]                          en_pipe_q, first_pipe_q;
    logic [S-1:1][ADDR_WIDTH-1:0]          addr_pipe_q;
    logic [S-1:0]                          stg_en, stg_first;
    logic [S-1:0][ADDR_WIDTH-1:0]          stg_addr;
    logic [S-1:0]                          col_en, col_first, bank_ovf;
    logic [S-1:0][ADDR_WIDTH-1:0]          col_addr;
    logic [S-1:0][PARTIAL_SUM_WIDTH-1:0]   psum_cols, col_psum;
    logic [S-1:0][ACC_WIDTH-1:0]           row_rd;

    assign busy  = (state_q != S_IDLE);
    assign en0   = wr_en & ~busy;
    // Test-mode writes bypass the skew line entirely; keeping them out of it
    // avoids delayed replays once test_mode drops.
    assign en_in = en0 & ~test_mode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_pipe_q    <= '0;
            first_pipe_q <= '0;
            addr_pipe_q  <= '0;
        end else begin
            en_pipe_q[1]    <= en_in;
            first_pipe_q[1] <= wr_first;
            addr_pipe_q[1]  <= wr_addr;
            for (int s = 2; s < S; s++) begin
                en_pipe_q[s]    <= en_pipe_q[s-1];
                first_pipe_q[s] <= first_pipe_q[s-1];
                addr_pipe_q[s]  <= addr_pipe_q[s-1];
            end
        end
    end

    // Stage i of the tuple is what column i sees this cycle.
    assign stg_en    = {en_pipe_q, en_in};
    assign stg_first = {first_pipe_q, wr_first};
    assign stg_addr  = {addr_pipe_q, wr_addr};
    assign psum_cols = psum_in_flat;

    for (genvar i = 0; i < S; i++) begin : g_col
        assign col_en[i]    = test_mode ? en0       : stg_en[i];
        assign col_first[i] = test_mode ? wr_first  : stg_first[i];
        assign col_addr[i]  = test_mode ? wr_addr   : stg_addr[i];
        assign col_psum[i]  = test_mode ? psum_test : psum_cols[i];

        acc_bank #(
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .PSUM_WIDTH (PARTIAL_SUM_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_bank (
            .clk        (clk),
            .wr_en_i    (col_en[i]),
            .wr_addr_i  (col_addr[i]),
            .wr_first_i (col_first[i]),
            .psum_i     (col_psum[i]),
            .rd_addr_i  (rd_addr),
            .rd_data_o  (row_rd[i]),
            .ovf_o      (bank_ovf[i])
        );
    end

    assign nxt_ptr = (rd_ptr_q == ADDR_WIDTH'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    // FLUSH fetches the base row; DRAIN prefetches the following row.
    assign rd_addr = (state_q == S_FLUSH) ? rd_ptr_q : nxt_ptr;

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        remain_d    = remain_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (drain_start) begin
                    rd_ptr_d = drain_base;
                    remain_d = drain_count;
                    if (drain_count == '0) done_d  = 1'b1;
                    else                   state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                // Wait until every skewed write in flight has landed.
                if (~|en_pipe_q) begin
                    out_data_d  = row_rd;
                    out_valid_d = 1'b1;
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (remain_q > (ADDR_WIDTH+1)'(1)) begin
                        rd_ptr_d   = nxt_ptr;
                        remain_d   = remain_q - 1'b1;
                        out_data_d = row_rd;
                    end else begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            remain_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            ovf_q       <= '0;
            conflict_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            remain_q    <= remain_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            ovf_q       <= clear_flags ? '0   : (ovf_q | bank_ovf);
            conflict_q  <= clear_flags ? 1'b0 : (conflict_q | (wr_en & busy));
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign drain_done  = done_q;
    assign ovf_flags   = ovf_q;
    assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_accumulator_rmw_bank.sv
module tb_accumulator_rmw_bank;

    localparam int S   = 4;
    localparam int PSW = 18;
    localparam int ACC = 22;
    localparam int D   = 8;
    localparam int AW  = 3;
    localparam int MAXV = 2097151;
    localparam int MINV = -2097152;

    logic clk = 1'b0;
    logic rst_n, test_mode, wr_en, wr_first, drain_start, out_ready, clear_flags;
    logic [AW-1:0] wr_addr, drain_base;
    logic [AW:0] drain_count;
    logic [PSW*S-1:0] psum_in_flat;
    logic [PSW-1:0] psum_test;
    logic out_valid, drain_done, busy, wr_conflict;
    logic [ACC*S-1:0] out_data;
    logic [S-1:0] ovf_flags;

    accumulator_rmw_bank #(.SYSTOLIC_SIZE(S), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .test_mode(test_mode), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_first(wr_first), .psum_in_flat(psum_in_flat),
        .psum_test(psum_test), .drain_start(drain_start), .drain_base(drain_base),
        .drain_count(drain_count), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .drain_done(drain_done), .busy(busy),
        .ovf_flags(ovf_flags), .wr_conflict(wr_conflict), .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [ACC*S-1:0] exp_q[$];
    logic [ACC*S-1:0] obs_q[$];
    logic [ACC*S-1:0] e, o;

    // burst stimulus tables
    int          b_n;
    logic [AW-1:0] b_addr[64];
    logic        b_first[64];
    int          b_val[64][S];
    logic        b_start = 1'b0;

    // drain observations
    int   done_cnt, stall_bad, flush_cyc;
    logic saw_valid;
    logic inj_en = 1'b0;
    logic [AW-1:0] inj_addr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ACC*S-1:0] mkrow(input int c0, input int c1, input int c2, input int c3);
        logic [ACC*S-1:0] r;
        r[0*ACC +: ACC] = ACC'(c0);
        r[1*ACC +: ACC] = ACC'(c1);
        r[2*ACC +: ACC] = ACC'(c2);
        r[3*ACC +: ACC] = ACC'(c3);
        return r;
    endfunction

    // Column i gets write k's data i cycles after write k is issued.
    task automatic burst();
        for (int c = 0; c < b_n + S - 1; c++) begin
            if (busy && !out_valid) flush_cyc++;
            wr_en       = (c < b_n);
            wr_addr     = (c < b_n) ? b_addr[c] : '0;
            wr_first    = (c < b_n) ? b_first[c] : 1'b0;
            drain_start = b_start && (c == b_n);
            for (int i = 0; i < S; i++) begin
                int k;
                k = c - i;
                psum_in_flat[i*PSW +: PSW] = (k >= 0 && k < b_n) ? PSW'(b_val[k][i]) : '0;
            end
            tick();
        end
        wr_en = 1'b0; drain_start = 1'b0; b_start = 1'b0;
    endtask

    // Drives a drain and collects accepted rows into obs_q.
    task automatic run_drain(input logic [AW-1:0] base, input logic [AW:0] cnt,
                             input logic start, input logic [7:0] pat, input int plen);
        logic [ACC*S-1:0] stall_data;
        logic have_stall;
        int pi;
        pi = 0; done_cnt = 0; stall_bad = 0; saw_valid = 1'b0; have_stall = 1'b0;
        stall_data = '0;
        if (start) begin
            drain_base = base; drain_count = cnt; drain_start = 1'b1;
            tick();
            drain_start = 1'b0;
        end
        for (int c = 0; c < 60; c++) begin
            if (out_valid) begin out_ready = pat[pi % plen]; pi++; end
            else out_ready = 1'b0;
            if (inj_en && out_valid) begin
                wr_en = 1'b1; wr_addr = inj_addr; wr_first = 1'b1;
                for (int i = 0; i < S; i++) psum_in_flat[i*PSW +: PSW] = PSW'(999);
                inj_en = 1'b0;
            end else wr_en = 1'b0;
            if (have_stall && out_data !== stall_data) stall_bad++;
            have_stall = out_valid && !out_ready;
            stall_data = out_data;
            if (out_valid) saw_valid = 1'b1;
            if (out_valid && out_ready) obs_q.push_back(out_data);
            if (busy && !out_valid) flush_cyc++;
            if (drain_done) begin
                done_cnt++;
                out_ready = 1'b0; wr_en = 1'b0;
                tick();
                if (drain_done) done_cnt++;
                break;
            end
            tick();
        end
        out_ready = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; test_mode = 1'b0; wr_en = 1'b0; wr_first = 1'b0; wr_addr = '0;
        drain_start = 1'b0; drain_base = '0; drain_count = '0; out_ready = 1'b0;
        clear_flags = 1'b0; psum_in_flat = '0; psum_test = '0;
        tick(); tick();
        rst_n = 1'b1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
        vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_data got %h want 0", out_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (drain_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", drain_done); end
        vectors++; if (ovf_flags !== '0) begin miscompares++; $display("FAIL reset_ovf got %h want 0", ovf_flags); end
        vectors++; if (wr_conflict !== 1'b0) begin miscompares++; $display("FAIL reset_conflict got %b want 0", wr_conflict); end
    endtask

    task automatic test_skew();
        b_n = 1; b_addr[0] = 3'd3; b_first[0] = 1'b1;
        for (int i = 0; i < S; i++) b_val[0][i] = 5;
        burst();
        exp_q.push_back(mkrow(5, 5, 5, 5));
        run_drain(3'd3, 4'd1, 1'b1, 8'h01, 1);
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL skew_done got %0d want 1", done_cnt); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            vectors++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            if (o !== e) begin miscompares++; $display("FAIL skew_row got %h want %h", o, e); end
        end
    endtask

    task automatic test_accumulate();
        b_n = 3;
        for (int k = 0; k < 3; k++) begin b_addr[k] = 3'd2; b_first[k] = (k == 0); end
        for (int i = 0; i < S; i++) begin b_val[0][i] = 10 + i; b_val[1][i] = -3; b_val[2][i] = 7; end
        burst();
        exp_q.push_back(mkrow(14, 15, 16, 17));
        run_drain(3'd2, 4'd1, 1'b1, 8'h01, 1);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            vectors++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            if (o !== e) begin miscompares++; $display("FAIL accum_row got %h want %h", o, e); end
        end
        vectors++; if (ovf_flags !== '0) begin miscompares++; $display("FAIL accum_ovf got %h want 0", ovf_flags); end
    endtask

    task automatic test_saturation();
        b_n = 41;
        for (int k = 0; k < 41; k++) begin
            b_addr[k] = 3'd5; b_first[k] = (k == 0);
            for (int i = 0; i < S; i++) b_val[k][i] = (i % 2) ? -131072 : 131071;
        end
        burst();
        vectors++; if (ovf_flags !== 4'hF) begin miscompares++; $display("FAIL sat_ovf got %h want f", ovf_flags); end
        clear_flags = 1'b1; tick(); clear_flags = 1'b0;
        vectors++; if (ovf_flags !== 4'h0) begin miscompares++; $display("FAIL sat_clear got %h want 0", ovf_flags); end
        // Column 0 overflows in the same cycle as clear_flags: clear wins there.
        for (int i = 0; i < S; i++) psum_in_flat[i*PSW +: PSW] = (i % 2) ? PSW'(-131072) : PSW'(131071);
        wr_en = 1'b1; wr_addr = 3'd5; wr_first = 1'b0; clear_flags = 1'b1;
        tick();
        wr_en = 1'b0; clear_flags = 1'b0;
        tick(); tick(); tick();
        vectors++; if (ovf_flags !== 4'hE) begin miscompares++; $display("FAIL sat_clear_prio got %h want e", ovf_flags); end
        exp_q.push_back(mkrow(MAXV, MINV, MAXV, MINV));
        run_drain(3'd5, 4'd1, 1'b1, 8'h01, 1);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            vectors++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            if (o !== e) begin miscompares++; $display("FAIL sat_row got %h want %h", o, e); end
        end
        clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    endtask

    task automatic test_wrap_backpressure();
        b_n = 4;
        for (int k = 0; k < 4; k++) begin
            b_addr[k] = AW'((6 + k) % D); b_first[k] = 1'b1;
            for (int i = 0; i < S; i++) b_val[k][i] = (((6 + k) % D) + 1) * 10 + i;
        end
        burst();
        for (int k = 0; k < 4; k++) begin
            int a;
            a = ((6 + k) % D + 1) * 10;
            exp_q.push_back(mkrow(a, a + 1, a + 2, a + 3));
        end
        // ready per valid cycle: 1,0,1,1,0,1 (bit 0 first)
        run_drain(3'd6, 4'd4, 1'b1, 8'b0010_1101, 6);
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL wrap_done got %0d want 1", done_cnt); end
        vectors++; if (stall_bad !== 0) begin miscompares++; $display("FAIL wrap_stall_stable got %0d want 0", stall_bad); end
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            vectors++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            if (o !== e) begin miscompares++; $display("FAIL wrap_row got %h want %h", o, e); end
        end
    endtask

    task automatic test_conflict_fsm();
        b_n = 1; b_addr[0] = 3'd4; b_first[0] = 1'b1;
        for (int i = 0; i < S; i++) b_val[0][i] = 20 + i;
        drain_base = 3'd4; drain_count = 4'd1; b_start = 1'b1; flush_cyc = 0;
        burst();
        exp_q.push_back(mkrow(20, 21, 22, 23));
        inj_en = 1'b1; inj_addr = 3'd4;
        run_drain(3'd4, 4'd1, 1'b0, 8'b10, 2);
        vectors++; if (flush_cyc !== 3) begin miscompares++; $display("FAIL flush_len got %0d want 3", flush_cyc); end
        vectors++; if (wr_conflict !== 1'b1) begin miscompares++; $display("FAIL conflict_set got %b want 1", wr_conflict); end
        exp_q.push_back(mkrow(20, 21, 22, 23));
        run_drain(3'd4, 4'd1, 1'b1, 8'h01, 1);
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            vectors++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            if (o !== e) begin miscompares++; $display("FAIL conflict_row got %h want %h", o, e); end
        end
        run_drain(3'd0, 4'd0, 1'b1, 8'h01, 1);
        vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL zero_count_done got %0d want 1", done_cnt); end
        vectors++; if (saw_valid !== 1'b0) begin miscompares++; $display("FAIL zero_count_valid got %b want 0", saw_valid); end
        vectors++; if (obs_q.size() !== 0) begin miscompares++; $display("FAIL zero_count_beats got %0d want 0", obs_q.size()); end
        obs_q.delete();
        clear_flags = 1'b1; tick(); clear_flags = 1'b0;
        vectors++; if (wr_conflict !== 1'b0) begin miscompares++; $display("FAIL conflict_clear got %b want 0", wr_conflict); end
    endtask

    task automatic test_testmode_reset();
        logic got_valid;
        test_mode = 1'b1; psum_test = PSW'(9);
        for (int i = 0; i < S; i++) psum_in_flat[i*PSW +: PSW] = PSW'(77);
        wr_en = 1'b1; wr_addr = 3'd1; wr_first = 1'b1;
        tick();
        wr_en = 1'b0; psum_test = PSW'(55);
        for (int i = 0; i < S; i++) psum_in_flat[i*PSW +: PSW] = PSW'(66);
        tick(); tick(); tick(); tick();
        exp_q.push_back(mkrow(9, 9, 9, 9));
        run_drain(3'd1, 4'd1, 1'b1, 8'h01, 1);
        test_mode = 1'b0;
        while (exp_q.size() > 0 || obs_q.size() > 0) begin
            vectors++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            if (o !== e) begin miscompares++; $display("FAIL testmode_row got %h want %h", o, e); end
        end
        // abort a stalled drain with reset
        drain_base = 3'd0; drain_count = 4'd8; drain_start = 1'b1; out_ready = 1'b0;
        tick();
        drain_start = 1'b0;
        got_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) begin got_valid = 1'b1; break; end
            tick();
        end
        vectors++; if (got_valid !== 1'b1) begin miscompares++; $display("FAIL abort_reach_drain got %b want 1", got_valid); end
        rst_n = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid got %b want 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
        vectors++; if (drain_done !== 1'b0) begin miscompares++; $display("FAIL abort_done got %b want 0", drain_done); end
        rst_n = 1'b1;
        tick();
        vectors++; if (drain_done !== 1'b0) begin miscompares++; $display("FAIL abort_done_after got %b want 0", drain_done); end
    endtask

    initial begin
        test_reset();
        test_skew();
        test_accumulate();
        test_saturation();
        test_wrap_backpressure();
        test_conflict_fsm();
        test_testmode_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
